// File: rtl/spi_peripheral_pkg.sv
// rvsteel_spi_pkg: shared definitions for the SPI peripheral endpoint.
//   spi_state_e     - FSM encodings (IDLE / ACTIVE)
//   SPI_BYTE_WIDTH  - bits per SPI byte
//   SPI_CNT_WIDTH   - width of the per-byte bit counters
//   SPI_DUMMY_BYTE  - byte shifted out when no TX data is pending
package rvsteel_spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int SPI_BYTE_WIDTH = 8;
  localparam int SPI_CNT_WIDTH  = $clog2(SPI_BYTE_WIDTH);

  localparam logic [SPI_BYTE_WIDTH-1:0] SPI_DUMMY_BYTE = 8'hFF;

endpackage

// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: byte-wide TX/RX valid/ready streams between the SPI
// peripheral and local logic.
//   tx_data/tx_valid -> peripheral, tx_ready <- peripheral
//   rx_data/rx_valid <- peripheral, rx_ready -> peripheral
// Modports: master = local logic side, slave = SPI peripheral side.
interface spi_peripheral_if;
  import rvsteel_spi_pkg::*;

  logic [SPI_BYTE_WIDTH-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [SPI_BYTE_WIDTH-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_peripheral_sync.sv
// spi_peripheral_sync: two-flop synchronizer for an asynchronous pin.
//   clock     - system clock
//   reset     - asynchronous active-low reset
//   d         - asynchronous input
//   q         - synchronized output (RESET_VAL while in reset)
module spi_peripheral_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI target endpoint, all pins oversampled in the clock domain.
//   clock, reset         - system clock, asynchronous active-low reset
//   cpol, cpha           - SPI mode, only changed while cs is high
//   sclk, pico, cs       - asynchronous SPI pins from the controller
//   poci, poci_oe        - data to controller and its pad enable
//   bus (slave)          - TX holding register write / RX byte stream
//   rx_overrun           - sticky overrun flag
//   rx_overrun_clear     - clears rx_overrun
// Build option: SPI_PERIPHERAL_OVERRUN_EN enables the rx_overrun flag;
// without it rx_overrun is tied low and rx_overrun_clear is ignored.
//
// state  | meaning
// IDLE   | cs high, sclk edges ignored, counters held at zero
// ACTIVE | cs low, sampling pico and shifting poci
module spi_peripheral
  import rvsteel_spi_pkg::*;
#(
  parameter logic [SPI_BYTE_WIDTH-1:0] DUMMY_BYTE = SPI_DUMMY_BYTE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic                   sclk,
  input  logic                   pico,
  input  logic                   cs,
  output logic                   poci,
  output logic                   poci_oe,
  spi_peripheral_if.slave        bus,
  output logic                   rx_overrun,
  input  logic                   rx_overrun_clear
);

  localparam logic [SPI_CNT_WIDTH-1:0] CNT_LAST = SPI_CNT_WIDTH'(SPI_BYTE_WIDTH - 1);

  logic sclk_s, pico_s, cs_s, sclk_q;

  spi_peripheral_sync #(.RESET_VAL(1'b0)) u_sync_sclk (.clock(clock), .reset(reset), .d(sclk), .q(sclk_s));
  spi_peripheral_sync #(.RESET_VAL(1'b0)) u_sync_pico (.clock(clock), .reset(reset), .d(pico), .q(pico_s));
  spi_peripheral_sync #(.RESET_VAL(1'b1)) u_sync_cs   (.clock(clock), .reset(reset), .d(cs),   .q(cs_s));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sclk_q <= 1'b0;
    else        sclk_q <= sclk_s;
  end

  spi_state_e state_q, state_d;
  logic       cs_fall, cs_rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cs_fall = 1'b0;
    cs_rise = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!cs_s) begin
          state_d = ST_ACTIVE;
          cs_fall = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cs_s) begin
          state_d = ST_IDLE;
          cs_rise = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Leading edge leaves the idle level cpol, trailing edge returns to it.
  logic active, sclk_edge, lead_edge, trail_edge, sample_evt, drive_evt;

  assign active     = (state_q == ST_ACTIVE);
  assign sclk_edge  = sclk_s ^ sclk_q;
  assign lead_edge  = sclk_edge & (sclk_q == cpol);
  assign trail_edge = sclk_edge & (sclk_s == cpol);
  assign sample_evt = active & (cpha ? trail_edge : lead_edge);
  assign drive_evt  = active & (cpha ? lead_edge : trail_edge);

  logic [SPI_CNT_WIDTH-1:0]  rx_cnt, tx_cnt;
  logic [SPI_BYTE_WIDTH-2:0] rx_shift;
  logic [SPI_BYTE_WIDTH-1:0] tx_shift, tx_hold;
  logic [SPI_BYTE_WIDTH-1:0] rx_data_q;
  logic                      rx_valid_q;
  logic                      tx_full, tx_write, tx_load, byte_done;

  // CPHA=0 has the MSB ready at cs fall and reloads on the 8th trailing edge;
  // CPHA=1 loads on the first leading edge of every byte.
  assign tx_load   = (cs_fall & ~cpha)
                   | (drive_evt & (cpha ? (tx_cnt == '0) : (tx_cnt == CNT_LAST)));
  assign tx_write  = bus.tx_valid & ~tx_full;
  assign byte_done = sample_evt & (rx_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else if (cs_rise) begin
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      if (sample_evt) begin
        rx_shift <= {rx_shift[SPI_BYTE_WIDTH-3:0], pico_s};
        rx_cnt   <= rx_cnt + 1'b1;
      end
      if (tx_load)        tx_shift <= tx_full ? tx_hold : DUMMY_BYTE;
      else if (drive_evt) tx_shift <= {tx_shift[SPI_BYTE_WIDTH-2:0], 1'b0};
      if (drive_evt)      tx_cnt   <= tx_cnt + 1'b1;
    end
  end

  // A write coinciding with a load lands after the load has already taken
  // the dummy byte, so the new byte waits for the next load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_hold <= '0;
      tx_full <= 1'b0;
    end else begin
      if (tx_load) tx_full <= 1'b0;
      if (tx_write) begin
        tx_hold <= bus.tx_data;
        tx_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (byte_done) begin
      rx_data_q  <= {rx_shift, pico_s};
      rx_valid_q <= 1'b1;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_q <= 1'b0;
    end
  end

`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                         overrun_q <= 1'b0;
    else if (byte_done && rx_valid_q && !bus.rx_ready)  overrun_q <= 1'b1;
    else if (rx_overrun_clear)                          overrun_q <= 1'b0;
  end

  assign rx_overrun = overrun_q;
`else
  logic unused_overrun_clear;
  assign unused_overrun_clear = rx_overrun_clear;
  assign rx_overrun           = 1'b0;
`endif

  assign bus.tx_ready = ~tx_full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign poci_oe      = ~cs_s;
  assign poci         = active & tx_shift[SPI_BYTE_WIDTH-1];

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed SPI controller model driving spi_peripheral.
// Expected RX bytes and expected controller read-back bytes are queued as
// stimulus is issued; a monitor process pops and compares them when the
// DUT presents rx_valid/rx_ready or the controller completes a byte.
module tb_spi_peripheral;
  import rvsteel_spi_pkg::*;

  localparam int CLK_HALF = 5;
  localparam int H        = 60;  // SCLK half period = 6 clocks

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, pico = 1'b0, cs = 1'b1;
  logic poci, poci_oe, rx_overrun;
  logic rx_overrun_clear = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] poci_obs[$];

  spi_peripheral_if bus();

  spi_peripheral dut (
    .clock            (clock),
    .reset            (reset),
    .cpol             (cpol),
    .cpha             (cpha),
    .sclk             (sclk),
    .pico             (pico),
    .cs               (cs),
    .poci             (poci),
    .poci_oe          (poci_oe),
    .bus              (bus),
    .rx_overrun       (rx_overrun),
    .rx_overrun_clear (rx_overrun_clear)
  );

  always #(CLK_HALF) clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT RX bytes and controller read-back bytes.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && bus.rx_valid && bus.rx_ready) begin
        if (rx_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got %0h expected no byte", bus.rx_data);
        end else begin
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, rx_exp.pop_front()});
        end
      end
      while (poci_obs.size() > 0) begin
        if (tx_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL poci_unexpected: got %0h expected no byte", poci_obs.pop_front());
        end else begin
          check("poci_byte", {24'd0, poci_obs.pop_front()}, {24'd0, tx_exp.pop_front()});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    clk_wait(8);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    clk_wait(6);
  endtask

  task automatic cs_high();
    clk_wait(4);
    cs = 1'b1;
    clk_wait(8);
  endtask

  task automatic write_tx(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    clk_wait(1);
    bus.tx_valid = 1'b0;
  endtask

  // Clocks n bits of b out MSB first; a full byte read from poci is queued.
  task automatic spi_bits(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        pico = b[7-i];
        #(H);
        r = {r[6:0], poci};
        sclk = ~cpol;
        #(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        pico = b[7-i];
        #(H);
        r = {r[6:0], poci};
        sclk = cpol;
        #(H);
      end
    end
    if (n == 8) poci_obs.push_back(r);
  endtask

  initial begin
    logic [1:0] mode;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;

    #23;
    check("rst_poci",       {31'd0, poci},         32'd0);
    check("rst_poci_oe",    {31'd0, poci_oe},      32'd0);
    check("rst_tx_ready",   {31'd0, bus.tx_ready}, 32'd1);
    check("rst_rx_data",    {24'd0, bus.rx_data},  32'd0);
    check("rst_rx_valid",   {31'd0, bus.rx_valid}, 32'd0);
    check("rst_rx_overrun", {31'd0, rx_overrun},   32'd0);
    @(posedge clock);
    #2 reset = 1'b1;
    clk_wait(4);

    // Mode 0 with a preloaded TX byte
    set_mode(1'b0, 1'b0);
    write_tx(8'hA5);
    check("tx_ready_after_write", {31'd0, bus.tx_ready}, 32'd0);
    rx_exp.push_back(8'h3C);
    tx_exp.push_back(8'hA5);
    cs_low();
    check("poci_oe_selected", {31'd0, poci_oe}, 32'd1);
    check("tx_ready_after_load", {31'd0, bus.tx_ready}, 32'd1);
    spi_bits(8'h3C, 8);
    cs_high();
    check("poci_oe_deselected", {31'd0, poci_oe}, 32'd0);

    // Modes 1..3, nothing loaded: dummy byte returned
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m);
      set_mode(mode[1], mode[0]);
      rx_exp.push_back(8'h81);
      tx_exp.push_back(8'hFF);
      cs_low();
      spi_bits(8'h81, 8);
      cs_high();
    end

    // Back-to-back bytes with rx_ready low
    set_mode(1'b0, 1'b0);
    bus.rx_ready = 1'b0;
    rx_exp.push_back(8'h34);
    tx_exp.push_back(8'hFF);
    tx_exp.push_back(8'hFF);
    cs_low();
    spi_bits(8'h12, 8);
    spi_bits(8'h34, 8);
    cs_high();
    check("b2b_rx_valid_held", {31'd0, bus.rx_valid}, 32'd1);
    check("b2b_rx_data_last",  {24'd0, bus.rx_data},  32'h34);
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    check("b2b_overrun", {31'd0, rx_overrun}, 32'd1);
`else
    check("b2b_overrun", {31'd0, rx_overrun}, 32'd0);
`endif
    bus.rx_ready = 1'b1;
    clk_wait(2);
    check("b2b_rx_valid_accepted", {31'd0, bus.rx_valid}, 32'd0);
    rx_overrun_clear = 1'b1;
    clk_wait(1);
    rx_overrun_clear = 1'b0;
    check("overrun_cleared", {31'd0, rx_overrun}, 32'd0);

    // Partial byte aborted by cs, then a full byte
    cs_low();
    spi_bits(8'hE7, 5);
    cs_high();
    check("partial_no_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    rx_exp.push_back(8'h5A);
    tx_exp.push_back(8'hFF);
    cs_low();
    spi_bits(8'h5A, 8);
    cs_high();

    // TX write in the same cycle as the cs-fall load
    rx_exp.push_back(8'h11);
    rx_exp.push_back(8'h22);
    tx_exp.push_back(8'hFF);
    tx_exp.push_back(8'hC3);
    cs = 1'b0;
    clk_wait(2);
    bus.tx_data  = 8'hC3;
    bus.tx_valid = 1'b1;
    clk_wait(1);
    bus.tx_valid = 1'b0;
    check("coincident_write_held", {31'd0, bus.tx_ready}, 32'd0);
    clk_wait(4);
    spi_bits(8'h11, 8);
    spi_bits(8'h22, 8);
    cs_high();
    check("coincident_hold_drained", {31'd0, bus.tx_ready}, 32'd1);

    // Asynchronous reset in the middle of a byte
    cs_low();
    spi_bits(8'hF0, 4);
    write_tx(8'h99);
    check("pre_reset_tx_full", {31'd0, bus.tx_ready}, 32'd0);
    check("pre_reset_poci",    {31'd0, poci},         32'd1);
    #4 reset = 1'b0;
    #1;
    check("async_rst_poci",       {31'd0, poci},         32'd0);
    check("async_rst_poci_oe",    {31'd0, poci_oe},      32'd0);
    check("async_rst_tx_ready",   {31'd0, bus.tx_ready}, 32'd1);
    check("async_rst_rx_data",    {24'd0, bus.rx_data},  32'd0);
    check("async_rst_rx_valid",   {31'd0, bus.rx_valid}, 32'd0);
    check("async_rst_rx_overrun", {31'd0, rx_overrun},   32'd0);
    cs   = 1'b1;
    sclk = cpol;
    clk_wait(3);
    reset = 1'b1;
    clk_wait(4);
    rx_exp.push_back(8'h77);
    tx_exp.push_back(8'hFF);
    cs_low();
    spi_bits(8'h77, 8);
    cs_high();

    clk_wait(10);
    check("rx_queue_drained", rx_exp.size(), 32'd0);
    check("tx_queue_drained", tx_exp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
